// File: rtl/prirv32_ifu_prefetch_if.sv
// priRV32 fetch-unit bus bundle: instruction memory request/response
// channel plus the {pc, inst} handshake toward decode.
interface prirv32_ifu_prefetch_if #(
    parameter int XLEN = 32
) ();
    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic [XLEN-1:0] mem_req_addr_o;
    logic            mem_rsp_valid_i;
    logic [XLEN-1:0] mem_rsp_data_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [XLEN-1:0] inst_data_o;
    logic [XLEN-1:0] inst_pc_o;

    modport master (
        output mem_req_valid_o, mem_req_addr_o,
        output inst_valid_o, inst_data_o, inst_pc_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  inst_ready_i
    );

    modport slave (
        input  mem_req_valid_o, mem_req_addr_o,
        input  inst_valid_o, inst_data_o, inst_pc_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output inst_ready_i
    );
endinterface

// File: rtl/prirv32_ifu_prefetch.sv
// priRV32 instruction prefetch unit with in-order outstanding fetches.
// Define PRIRV32_IFU_MISALIGN_EN to trap misaligned redirects in FAULT.
module prirv32_ifu_prefetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            fetch_en_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fetch_fault_o,
    prirv32_ifu_prefetch_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 2;
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

`ifdef PRIRV32_IFU_MISALIGN_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_e;
`else
    typedef enum logic {S_IDLE, S_RUN} state_e;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [QW-1:0]   qrd_q, qrd_d, qwr_q, qwr_d;

    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] iq_pc     [MAX_OUTST];

    logic [XLEN-1:0] tgt;
    logic [OW-1:0]   occ;
    logic            req_valid, fire, rsp_keep, rsp_drop;
    logic            push, pop, mis;

    function automatic logic [QW-1:0] qnext(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tgt = redirect_pc_i & ~(XLEN'(3));
`ifdef PRIRV32_IFU_MISALIGN_EN
    assign mis = |redirect_pc_i[1:0];
`else
    assign mis = 1'b0;
`endif

    // Slots already promised (queued + in flight + to be discarded)
    // bound issue so every response always has room.
    assign occ = OW'(cnt_q) + OW'(outst_q) + OW'(drop_q);
    assign req_valid = (state_q == S_RUN) && !redirect_i
                    && (outst_q < CW'(MAX_OUTST))
                    && (occ < OW'(FIFO_DEPTH));
    assign fire     = req_valid && bus.mem_req_ready_i;
    assign rsp_keep = bus.mem_rsp_valid_i && (drop_q == '0);
    assign rsp_drop = bus.mem_rsp_valid_i && (drop_q != '0);
    assign push     = rsp_keep && !redirect_i;
    assign pop      = (cnt_q != '0) && bus.inst_ready_i && !redirect_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        qrd_d   = qrd_q;
        qwr_d   = qwr_q;

        unique case (state_q)
            S_IDLE:  if (fetch_en_i) state_d = S_RUN;
            S_RUN:   if (!fetch_en_i) state_d = S_IDLE;
`ifdef PRIRV32_IFU_MISALIGN_EN
            S_FAULT: if (redirect_i) state_d = S_RUN;
`endif
            default: state_d = S_IDLE;
        endcase

        if (redirect_i) begin
            pc_d    = tgt;
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            qrd_d   = '0;
            qwr_d   = '0;
            outst_d = '0;
            drop_d  = drop_q + outst_q - CW'(bus.mem_rsp_valid_i);
`ifdef PRIRV32_IFU_MISALIGN_EN
            if (mis) state_d = S_FAULT;
`endif
        end else begin
            if (fire) begin
                pc_d  = pc_q + XLEN'(4);
                qwr_d = qnext(qwr_q);
            end
            if (rsp_keep) qrd_d = qnext(qrd_q);
            if (push) wr_d = wr_q + 1'b1;
            if (pop) rd_d = rd_q + 1'b1;
            outst_d = outst_q + CW'(fire) - CW'(rsp_keep);
            drop_d  = drop_q - CW'(rsp_drop);
            cnt_d   = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            qrd_q   <= '0;
            qwr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            qrd_q   <= qrd_d;
            qwr_q   <= qwr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) iq_pc[qwr_q] <= pc_q;
        if (push) begin
            fifo_pc[wr_q]   <= iq_pc[qrd_q];
            fifo_data[wr_q] <= bus.mem_rsp_data_i;
        end
    end

`ifdef PRIRV32_IFU_MISALIGN_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (redirect_i) fault_d = mis;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else fault_q <= fault_d;
    end

    assign fetch_fault_o = fault_q;
`else
    assign fetch_fault_o = mis;
`endif

    assign bus.mem_req_valid_o = req_valid;
    assign bus.mem_req_addr_o  = pc_q;
    assign bus.inst_valid_o    = (cnt_q != '0);
    assign bus.inst_pc_o   = (cnt_q != '0) ? fifo_pc[rd_q] : '0;
    assign bus.inst_data_o = (cnt_q != '0) ? fifo_data[rd_q] : '0;
endmodule

// File: tb/tb_prirv32_ifu_prefetch.sv
// Bench for prirv32_ifu_prefetch: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_prirv32_ifu_prefetch;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fault;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;

    prirv32_ifu_prefetch_if #(.XLEN(32)) ifc ();

    prirv32_ifu_prefetch #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTST(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_n(rst_n),
        .fetch_en_i(fetch_en),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .fetch_fault_o(fault),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_q[$];

    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    int          m_drop;
    logic [31:0] m_fifo[$];
    logic        m_fault;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory: in-order responses, each valid from its due cycle on.
    always @(posedge clk) begin
        #2;
        if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
            ifc.mem_rsp_valid_i = 1'b1;
            ifc.mem_rsp_data_i  = memfun(mq[0].addr);
        end else begin
            ifc.mem_rsp_valid_i = 1'b0;
            ifc.mem_rsp_data_i  = '0;
        end
    end

    always @(negedge clk) begin
        bit          exp_v, fire_m, pop_m, rsp, mis;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_st = 0;
            m_pc = '0;
            m_infl.delete();
            m_drop = 0;
            m_fifo.delete();
            m_fault = 1'b0;
            mq.delete();
        end else begin
            exp_v = (m_st == 1) && !redirect && (m_infl.size() < MAXO)
                 && (m_fifo.size() + m_infl.size() + m_drop < DEPTH);
            chk("req_valid", 32'(ifc.mem_req_valid_o), 32'(exp_v));
            if (exp_v) chk("req_addr", ifc.mem_req_addr_o, m_pc);
            chk("inst_valid", 32'(ifc.inst_valid_o), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) begin
                chk("inst_pc", ifc.inst_pc_o, m_fifo[0]);
                chk("inst_data", ifc.inst_data_o, memfun(m_fifo[0]));
            end
            chk("fault", 32'(fault), 32'(m_fault));

            rsp = ifc.mem_rsp_valid_i;
            if (rsp && mq.size() > 0) void'(mq.pop_front());
            if (ifc.mem_req_valid_o && ifc.mem_req_ready_i) begin
                acc_q.push_back(ifc.mem_req_addr_o);
                mq.push_back('{ifc.mem_req_addr_o, cyc + lat});
            end
            if (ifc.inst_valid_o && ifc.inst_ready_i && !redirect)
                pop_q.push_back(ifc.inst_pc_o);

            fire_m = exp_v && ifc.mem_req_ready_i;
            pop_m  = (m_fifo.size() > 0) && ifc.inst_ready_i;
            if (redirect) begin
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else void'(m_infl.pop_front());
                end
                m_drop += m_infl.size();
                m_infl.delete();
                m_fifo.delete();
                tgt = redirect_pc;
                mis = 1'b0;
`ifdef PRIRV32_IFU_MISALIGN_EN
                mis = (tgt[1:0] != 2'b00);
`endif
                tgt[1:0] = 2'b00;
                m_pc = tgt;
                if (mis) begin
                    m_st = 2;
                    m_fault = 1'b1;
                end else begin
                    m_fault = 1'b0;
                    m_st = (m_st == 2 || fetch_en) ? 1 : 0;
                end
            end else begin
                if (pop_m) void'(m_fifo.pop_front());
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else m_fifo.push_back(m_infl.pop_front());
                end
                if (fire_m) begin
                    m_infl.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
                if (m_st != 2) m_st = fetch_en ? 1 : 0;
            end
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect = 1'b1;
        redirect_pc = a;
        acc_q.delete();
        pop_q.delete();
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        ifc.mem_req_ready_i = 1'b0;
        ifc.inst_ready_i    = 1'b0;
        ifc.mem_rsp_valid_i = 1'b0;
        ifc.mem_rsp_data_i  = '0;
        tick(2);
        @(negedge clk);
        chk("rst_req_valid", 32'(ifc.mem_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(ifc.inst_valid_o), 32'd0);
        chk("rst_addr", ifc.mem_req_addr_o, 32'h0);
        chk("rst_inst_pc", ifc.inst_pc_o, 32'h0);
        chk("rst_inst_data", ifc.inst_data_o, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        tick();
        rst_n = 1'b1;

        // sequential fetch, 1-cycle memory
        fetch_en = 1'b1;
        ifc.mem_req_ready_i = 1'b1;
        ifc.inst_ready_i = 1'b1;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", qat(acc_q, i), 32'(4 * i));
            chk("t1_pc", qat(pop_q, i), 32'(4 * i));
        end

        // back-pressure from decode fills the FIFO
        fetch_en = 1'b0;
        tick(6);
        ifc.inst_ready_i = 1'b0;
        acc_q.delete();
        pop_q.delete();
        fetch_en = 1'b1;
        tick(12);
        chk("t2_nreq", 32'(acc_q.size()), 32'd4);
        ifc.inst_ready_i = 1'b1;
        tick();
        ifc.inst_ready_i = 1'b0;
        tick(6);
        chk("t2_nreq_pop", 32'(acc_q.size()), 32'd5);
        chk("t2_npop", 32'(pop_q.size()), 32'd1);

        // redirect with two fetches in flight
        ifc.inst_ready_i = 1'b1;
        lat = 3;
        redir(32'h80);
        tick(2);
        redir(32'h100);
        @(negedge clk);
        chk("t3_empty", 32'(ifc.inst_valid_o), 32'd0);
        tick(10);
        chk("t3_addr", qat(acc_q, 0), 32'h100);
        chk("t3_pc0", qat(pop_q, 0), 32'h100);
        chk("t3_pc1", qat(pop_q, 1), 32'h104);

        // memory stalls the request
        lat = 1;
        ifc.mem_req_ready_i = 1'b0;
        redir(32'h8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_valid", 32'(ifc.mem_req_valid_o), 32'd1);
            chk("t4_addr", ifc.mem_req_addr_o, 32'h8);
            tick();
        end
        ifc.mem_req_ready_i = 1'b1;
        tick();
        chk("t4_acc", qat(acc_q, 0), 32'h8);
        chk("t4_nacc", 32'(acc_q.size()), 32'd1);
        tick(4);

        // address wrap
        redir(32'hFFFF_FFFC);
        tick(4);
        chk("t5_top", qat(acc_q, 0), 32'hFFFF_FFFC);
        chk("t5_wrap", qat(acc_q, 1), 32'h0);
        chk("t5_wrap_pc", qat(pop_q, 1), 32'h0);

        // disable with one fetch in flight
        lat = 3;
        redir(32'h300);
        fetch_en = 1'b0;
        tick(8);
        chk("t5_nacc", 32'(acc_q.size()), 32'd1);
        chk("t5_npop", 32'(pop_q.size()), 32'd1);
        chk("t5_pc", qat(pop_q, 0), 32'h300);

        // misaligned redirect
        lat = 1;
        fetch_en = 1'b1;
        redir(32'h102);
`ifdef PRIRV32_IFU_MISALIGN_EN
        @(negedge clk);
        chk("t6_fault", 32'(fault), 32'd1);
        chk("t6_noreq", 32'(ifc.mem_req_valid_o), 32'd0);
        tick(3);
        chk("t6_nacc", 32'(acc_q.size()), 32'd0);
        redir(32'h200);
        @(negedge clk);
        chk("t6_clear", 32'(fault), 32'd0);
        tick(4);
        chk("t6_resume", qat(acc_q, 0), 32'h200);
`else
        tick(4);
        chk("t6_align", qat(acc_q, 0), 32'h100);
        chk("t6_nofault", 32'(fault), 32'd0);
`endif

        // reset while busy
        tick(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_req_valid", 32'(ifc.mem_req_valid_o), 32'd0);
        chk("t7_inst_valid", 32'(ifc.inst_valid_o), 32'd0);
        chk("t7_addr", ifc.mem_req_addr_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
